// File: rtl/mem_slave_model.sv
// Clocked off-chip memory responder with programmable read/write wait states and byte-lane writes.
// Optional out-of-range detection and mem_err port are enabled by defining MEM_SLAVE_ERR_EN.
module mem_slave_model #(
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 32,
   parameter int    DEPTH_LOG2 = 13,
   parameter int    ADDR_LSB   = 0,
   parameter int    READ_LAT   = 2,
   parameter int    WRITE_LAT  = 1,
   parameter string INIT_FILE  = ""
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic                    mem_write_en,
   input  logic                    mem_read_en,
   input  logic [DATA_WIDTH/8-1:0] mem_byte_size,
   input  logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH-1:0]   mem_data,
   output logic                    mem_ready
`ifdef MEM_SLAVE_ERR_EN
   ,
   output logic                    mem_err
`endif
);

   // state | meaning
   // IDLE  | waiting for a request; accepts on any edge with an enable high
   // WAIT  | counting down wait states on the latched request
   // DONE  | access complete, mem_ready held until both enables drop

   localparam int NB      = DATA_WIDTH / 8;
   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int HI_LSB  = ADDR_LSB + DEPTH_LOG2;
   localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

   state_t                  state, state_d;
   logic [CNT_W-1:0]        cnt, cnt_d;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NB-1:0]           be_q;
   logic                    wr_q, oor_q;

   logic                    req, oor_in;
   logic [CNT_W-1:0]        load;
   logic                    cur_wr, cur_oor;
   logic [DEPTH_LOG2-1:0]   cur_idx;
   logic [DATA_WIDTH-1:0]   cur_wdata;
   logic [NB-1:0]           cur_be;
   logic                    enter_done, commit_wr, ready_d;
   logic                    unused_addr;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   assign req         = mem_write_en | mem_read_en;
   assign load        = mem_write_en ? WR_LOAD : RD_LOAD;
   assign unused_addr = ^mem_addr;

`ifdef MEM_SLAVE_ERR_EN
   generate
      if (HI_LSB < ADDR_WIDTH) begin : g_oor
         assign oor_in = |mem_addr[ADDR_WIDTH-1:HI_LSB];
      end else begin : g_no_oor
         assign oor_in = 1'b0;
      end
   endgenerate
`else
   assign oor_in = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         wr_q    <= 1'b0;
         oor_q   <= 1'b0;
      end else if (state == S_IDLE && req) begin
         idx_q   <= mem_addr[ADDR_LSB +: DEPTH_LOG2];
         wdata_q <= mem_wdata;
         be_q    <= mem_byte_size;
         wr_q    <= mem_write_en;
         oor_q   <= oor_in;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         S_IDLE: begin
            if (req) begin
               cnt_d   = load;
               state_d = (load == '0) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt - 1'b1;
            if (cnt == CNT_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (!req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // With a one-cycle latency the access completes on the accept edge, so the live inputs are used.
   always_comb begin
      cur_wr    = wr_q;
      cur_oor   = oor_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
      if (state == S_IDLE) begin
         cur_wr    = mem_write_en;
         cur_oor   = oor_in;
         cur_idx   = mem_addr[ADDR_LSB +: DEPTH_LOG2];
         cur_wdata = mem_wdata;
         cur_be    = mem_byte_size;
      end
      enter_done = 1'b0;
      case (state)
         S_IDLE:  enter_done = req && (load == '0);
         S_WAIT:  enter_done = (cnt == CNT_W'(1));
         default: enter_done = 1'b0;
      endcase
      commit_wr = rst && enter_done && cur_wr && !cur_oor;
      ready_d   = mem_ready;
      if (enter_done)                   ready_d = 1'b1;
      else if (state == S_DONE && !req) ready_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_ready <= 1'b0;
         mem_data  <= '0;
`ifdef MEM_SLAVE_ERR_EN
         mem_err   <= 1'b0;
`endif
      end else begin
         mem_ready <= ready_d;
         if (enter_done && !cur_wr) mem_data <= cur_oor ? '0 : mem[cur_idx];
`ifdef MEM_SLAVE_ERR_EN
         if (enter_done)                   mem_err <= cur_oor;
         else if (state == S_DONE && !req) mem_err <= 1'b0;
`endif
      end
   end

   // Array has no reset: contents survive rst.
   always_ff @(posedge clk) begin
      if (commit_wr) begin
         for (int k = 0; k < NB; k++) begin
            if (cur_be[k]) mem[cur_idx][8*k +: 8] <= cur_wdata[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_slave_model.sv
// Self-checking bench for mem_slave_model: two instances (latency 2/1 and 4/3) share one stimulus stream.
module tb_mem_slave_model;
  localparam int NI = 2;
`ifdef MEM_SLAVE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, re;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [1:0][31:0] data_o;
  logic [1:0]  ready_o;
`ifdef MEM_SLAVE_ERR_EN
  logic [1:0]  err_o;
`endif

  mem_slave_model #(.READ_LAT(2), .WRITE_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_write_en(we), .mem_read_en(re),
    .mem_byte_size(be), .mem_wdata(wdata), .mem_data(data_o[0]), .mem_ready(ready_o[0])
`ifdef MEM_SLAVE_ERR_EN
    , .mem_err(err_o[0])
`endif
  );

  mem_slave_model #(.READ_LAT(4), .WRITE_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_write_en(we), .mem_read_en(re),
    .mem_byte_size(be), .mem_wdata(wdata), .mem_data(data_o[1]), .mem_ready(ready_o[1])
`ifdef MEM_SLAVE_ERR_EN
    , .mem_err(err_o[1])
`endif
  );

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] mdl [NI][8192];
  logic [31:0] last_rd [NI];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int rlat(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int wlat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
    return ERR_ON && ((a >> 13) != 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One full handshake; caller is at a negedge. Expected results come from the word-array model.
  task automatic xfer(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input bit scramble);
    int          lat [NI];
    bit          seen [NI];
    int          n;
    bit          oor;
    logic [12:0] idx;
    logic [31:0] exp;
    for (int i = 0; i < NI; i++) begin lat[i] = 0; seen[i] = 0; end
    addr = a; wdata = d; be = b; we = w; re = r;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
      for (int i = 0; i < NI; i++)
        if (!seen[i] && ready_o[i]) begin seen[i] = 1; lat[i] = n; end
      if (scramble) begin addr = $urandom; wdata = $urandom; be = 4'($urandom); end
    end while (!(seen[0] && seen[1]) && n < 20);
    oor = is_oor(a);
    idx = a[12:0];
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("latency[%0d]", i), lat[i], w ? wlat(i) : rlat(i));
      if (w) begin
        if (!oor)
          for (int k = 0; k < 4; k++)
            if (b[k]) mdl[i][idx][8*k +: 8] = d[8*k +: 8];
        chk($sformatf("data_hold[%0d]", i), data_o[i], last_rd[i]);
      end else begin
        exp = oor ? 32'h0 : mdl[i][idx];
        chk($sformatf("rd_data[%0d]", i), data_o[i], exp);
        last_rd[i] = exp;
      end
`ifdef MEM_SLAVE_ERR_EN
      chk($sformatf("err[%0d]", i), err_o[i], oor);
`endif
    end
    we = 0; re = 0;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ready_drop[%0d]", i), ready_o[i], 1'b0);
`ifdef MEM_SLAVE_ERR_EN
      chk($sformatf("err_drop[%0d]", i), err_o[i], 1'b0);
`endif
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [14];
    logic [31:0] rnd, a;
    bit          w, r;

    tbl[0]  = '{1, 0, 32'h10,   32'hDEADBEEF, 4'hF,    32'h0};
    tbl[1]  = '{0, 1, 32'h10,   32'h0,        4'hF,    32'hDEADBEEF};
    tbl[2]  = '{1, 0, 32'h10,   32'h11223344, 4'b0101, 32'h0};
    tbl[3]  = '{0, 1, 32'h10,   32'h0,        4'h0,    32'hDE22BE44};
    tbl[4]  = '{1, 0, 32'h20,   32'hA5A5A5A5, 4'hF,    32'h0};
    tbl[5]  = '{1, 0, 32'h40,   32'h0,        4'hF,    32'h0};
    tbl[6]  = '{1, 0, 32'h05,   32'h55555555, 4'hF,    32'h0};
    tbl[7]  = '{1, 0, 32'h2005, 32'h12345678, 4'hF,    32'h0};
    tbl[8]  = '{0, 1, 32'h0005, 32'h0,        4'hF,    ERR_ON ? 32'h55555555 : 32'h12345678};
    tbl[9]  = '{0, 1, 32'h2005, 32'h0,        4'hF,    ERR_ON ? 32'h0 : 32'h12345678};
    tbl[10] = '{1, 1, 32'h30,   32'h0F0F0F0F, 4'hF,    32'h0};
    tbl[11] = '{0, 1, 32'h30,   32'h0,        4'hF,    32'h0F0F0F0F};
    tbl[12] = '{1, 0, 32'h30,   32'hFFFFFFFF, 4'h0,    32'h0};
    tbl[13] = '{0, 1, 32'h30,   32'h0,        4'hF,    32'h0F0F0F0F};

    rst = 0; we = 0; re = 0; addr = 0; wdata = 0; be = 0;
    for (int i = 0; i < NI; i++) last_rd[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_ready[%0d]", i), ready_o[i], 1'b0);
      chk($sformatf("reset_data[%0d]", i), data_o[i], 32'h0);
    end
    rst = 1;

    for (int i = 0; i <= 64; i++) xfer(1, 0, 32'(i), $urandom, 4'hF, 0);

    for (int j = 0; j < 14; j++) begin
      xfer(tbl[j].w, tbl[j].r, tbl[j].a, tbl[j].d, tbl[j].b, 0);
      if (tbl[j].r && !tbl[j].w)
        for (int i = 0; i < NI; i++)
          chk($sformatf("tbl%0d_data[%0d]", j, i), data_o[i], tbl[j].exp);
    end

    // Reset held with a read pending.
    rst = 0; re = 1; addr = 32'h10;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("rsthold_ready[%0d]", i), ready_o[i], 1'b0);
        chk($sformatf("rsthold_data[%0d]", i), data_o[i], 32'h0);
      end
    end
    for (int i = 0; i < NI; i++) last_rd[i] = 32'h0;
    rst = 1;
    xfer(0, 1, 32'h10, 32'h0, 4'hF, 0);

    // Address change and enable withdrawal during the wait states.
    addr = 32'h20; re = 1; we = 0; be = 4'hF;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (n < rlat(i)) chk($sformatf("midwait_early[%0d]", i), ready_o[i], 1'b0);
        else if (n == rlat(i)) begin
          chk($sformatf("midwait_ready[%0d]", i), ready_o[i], 1'b1);
          chk($sformatf("midwait_data[%0d]", i), data_o[i], 32'hA5A5A5A5);
        end else if (n == rlat(i) + 1) chk($sformatf("midwait_drop[%0d]", i), ready_o[i], 1'b0);
      end
      if (n == 1) begin addr = 32'h30; re = 0; end
    end
    for (int i = 0; i < NI; i++) last_rd[i] = 32'hA5A5A5A5;

    // Reset one cycle after accepting a write; only the 1-cycle instance has committed.
    addr = 32'h40; wdata = 32'hCAFEF00D; be = 4'hF; we = 1;
    @(posedge clk); @(negedge clk);
    rst = 0; we = 0;
    #1;
    for (int i = 0; i < NI; i++) chk($sformatf("rstwr_ready[%0d]", i), ready_o[i], 1'b0);
    mdl[0][13'h40] = 32'hCAFEF00D;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("rstwr_ready_b", ready_o[1], 1'b0);
    end
    rst = 1;
    for (int i = 0; i < NI; i++) last_rd[i] = 32'h0;
    xfer(0, 1, 32'h40, 32'h0, 4'hF, 0);
    chk("rstwr_data_b", data_o[1], 32'h0);

    for (int t = 0; t < 40; t++) begin
      w   = 1'($urandom);
      r   = w ? 1'($urandom) : 1'b1;
      rnd = $urandom;
      a   = 32'($urandom_range(0, 64));
      if ($urandom_range(0, 3) == 0) a = {rnd[31:13], a[12:0]};
      xfer(w, r, a, $urandom, 4'($urandom_range(0, 15)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
